heu_unit: RTL and testbench

Histogram equalization unit: accepts a full 20x20 8-bit window from the BCAU, builds a 256-bin histogram, converts it to a cumulative distribution, and remaps every pixel so the output window spans the full 0..255 range. It sits directly downstream of the BCAU and upstream of the neural-network stage (NNU). Both sides use a valid/ready handshake, and whole windows are transferred in parallel.

---
 rtl/heu_pkg.sv | 29 ++
 rtl/heu_hist_mem.sv | 52 +++++
 rtl/heu_unit.sv | 130 +++++++++++++
 tb/tb_heu_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/heu_pkg.sv
// Shared definitions for the histogram equalization unit: window geometry,
// Q10 mapping constant, FSM state encoding and the parallel window type.
package heu_pkg;

    localparam int WIN_PIXELS = 400;
    localparam int NUM_BINS   = 256;
    localparam int SCALE_Q10  = 653;   // round(255*1024/WIN_PIXELS)
    localparam int WIN_BITS   = WIN_PIXELS * 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HIST = 3'd1,
        CDF  = 3'd2,
        MAP  = 3'd3,
        DONE = 3'd4
    } heu_state_t;

    // Whole BCAU-to-HEU window, element 0 is pixel 0 (least significant byte).
    typedef logic [WIN_PIXELS-1:0][7:0] heu_window_t;

    // Map a cumulative count to the output range: (cdf * SCALE_Q10) >> 10,
    // saturated at 255 in case the constants are ever changed.
    function automatic logic [7:0] heu_scale(input logic [8:0] cdf_val);
        logic [8:0] scaled;
        scaled = 9'(({10'd0, cdf_val} * 19'(SCALE_Q10)) >> 10);
        return scaled[8] ? 8'hFF : scaled[7:0];
    endfunction

endpackage

// File: rtl/heu_hist_mem.sv
// Histogram and CDF storage: 256 x 9-bit bins each, combinational read,
// synchronous write. The histogram has an increment port and a clear port;
// everything is cleared by the asynchronous active-low reset.
module heu_hist_mem
    import heu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_en,
    input  logic [7:0] inc_addr,
    input  logic       clr_en,
    input  logic [7:0] clr_addr,
    input  logic [7:0] hist_addr,
    output logic [8:0] hist_data,
    input  logic       cdf_we,
    input  logic [7:0] cdf_waddr,
    input  logic [8:0] cdf_wdata,
    input  logic [7:0] cdf_raddr,
    output logic [8:0] cdf_rdata
);

    logic [8:0] hist_reg [NUM_BINS];
    logic [8:0] cdf_reg  [NUM_BINS];

    assign hist_data = hist_reg[hist_addr];
    assign cdf_rdata = cdf_reg[cdf_raddr];

    // Histogram bins: clear wins over increment (they never overlap in use).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                hist_reg[i] <= '0;
            end
        end else if (clr_en) begin
            hist_reg[clr_addr] <= '0;
        end else if (inc_en) begin
            hist_reg[inc_addr] <= hist_reg[inc_addr] + 9'd1;
        end
    end

    // Cumulative distribution bins, written once per window during CDF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                cdf_reg[i] <= '0;
            end
        end else if (cdf_we) begin
            cdf_reg[cdf_waddr] <= cdf_wdata;
        end
    end

endmodule

// File: rtl/heu_unit.sv
// Histogram equalization unit. Takes a 20x20 window, histograms it while
// rotating a circular pixel buffer, builds the CDF (clearing the histogram
// as it goes), then remaps each pixel through the CDF on a second rotation.
// Optional feature macro: HEU_BYPASS_EN adds a bypass input that skips
// equalization and returns the latched window unchanged.
module heu_unit
    import heu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bcau_valid,
    input  logic [WIN_PIXELS*8-1:0]   bcau_window,
    output logic                      heu_ready,
    output logic                      heu_valid,
    output logic [WIN_PIXELS*8-1:0]   heu_window,
`ifdef HEU_BYPASS_EN
    input  logic                      bypass,
`endif
    input  logic                      nnu_ready
);

    heu_state_t  state_reg;
    logic [8:0]  cnt_reg;
    logic [8:0]  acc_reg;
    heu_window_t pix_reg;

    logic        bypass_sel;
    logic        accept;
    logic [7:0]  head_pix;
    logic [7:0]  tail_next;
    logic [8:0]  hist_data;
    logic [8:0]  cdf_rdata;
    logic [8:0]  cdf_wdata;

`ifdef HEU_BYPASS_EN
    assign bypass_sel = bypass;
`else
    assign bypass_sel = 1'b0;
`endif

    // Ready is Moore on IDLE but forced low while reset is held.
    assign heu_ready  = rst_n && (state_reg == IDLE);
    assign heu_valid  = (state_reg == DONE);
    assign heu_window = pix_reg;

    assign accept    = (state_reg == IDLE) && bcau_valid;
    assign head_pix  = pix_reg[0];
    assign cdf_wdata = acc_reg + hist_data;
    // In MAP the head pixel is replaced by its equalized value; in HIST it
    // is simply rotated so the original order comes back after 400 steps.
    assign tail_next = (state_reg == MAP) ? heu_scale(cdf_rdata) : head_pix;

    heu_hist_mem u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_en    (state_reg == HIST),
        .inc_addr  (head_pix),
        .clr_en    (state_reg == CDF),
        .clr_addr  (cnt_reg[7:0]),
        .hist_addr (cnt_reg[7:0]),
        .hist_data (hist_data),
        .cdf_we    (state_reg == CDF),
        .cdf_waddr (cnt_reg[7:0]),
        .cdf_wdata (cdf_wdata),
        .cdf_raddr (head_pix),
        .cdf_rdata (cdf_rdata)
    );

    // Control FSM with the shared step counter and CDF accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg   <= '0;
                        state_reg <= bypass_sel ? DONE : HIST;
                    end
                end
                HIST: begin
                    if (cnt_reg == 9'(WIN_PIXELS - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= CDF;
                    end else begin
                        cnt_reg <= cnt_reg + 9'd1;
                    end
                end
                CDF: begin
                    if (cnt_reg == 9'(NUM_BINS - 1)) begin
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                        state_reg <= MAP;
                    end else begin
                        cnt_reg <= cnt_reg + 9'd1;
                        acc_reg <= cdf_wdata;
                    end
                end
                MAP: begin
                    if (cnt_reg == 9'(WIN_PIXELS - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 9'd1;
                    end
                end
                DONE: begin
                    if (nnu_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Circular pixel buffer: load on accept, rotate toward pixel 0 in HIST/MAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_reg <= '0;
        end else if (accept) begin
            pix_reg <= bcau_window;
        end else if (state_reg == HIST || state_reg == MAP) begin
            pix_reg <= {tail_next, pix_reg[WIN_PIXELS-1:1]};
        end
    end

endmodule

// File: tb/tb_heu_unit.sv
// Directed bench for heu_unit: two-value window vectors from a table, plus
// ramp, backpressure, mid-operation reset and (optionally) bypass sequences.
module tb_heu_unit;
    import heu_pkg::*;

    localparam int WB = WIN_PIXELS * 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bcau_valid = 1'b0;
    logic [WB-1:0] bcau_window = '0;
    logic          nnu_ready = 1'b1;
    logic          heu_ready;
    logic          heu_valid;
    logic [WB-1:0] heu_window;
`ifdef HEU_BYPASS_EN
    logic          bypass = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    heu_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcau_valid  (bcau_valid),
        .bcau_window (bcau_window),
        .heu_ready   (heu_ready),
        .heu_valid   (heu_valid),
        .heu_window  (heu_window),
`ifdef HEU_BYPASS_EN
        .bypass      (bypass),
`endif
        .nnu_ready   (nnu_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;   // even pixels
        logic [7:0] b;   // odd pixels
        logic [7:0] ea;  // expected at even positions
        logic [7:0] eb;  // expected at odd positions
    } vec_t;

    vec_t vecs[6];

    function automatic logic [WB-1:0] mk_win(input logic [7:0] a, input logic [7:0] b);
        logic [WB-1:0] w;
        for (int i = 0; i < WIN_PIXELS; i++) begin
            w[8*i +: 8] = (i % 2 == 0) ? a : b;
        end
        return w;
    endfunction

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_win(input string name, input logic [WB-1:0] exp);
        int bad_idx;
        bad_idx = -1;
        checks++;
        for (int i = 0; i < WIN_PIXELS; i++) begin
            if (bad_idx < 0 && heu_window[8*i +: 8] !== exp[8*i +: 8]) bad_idx = i;
        end
        if (bad_idx >= 0) begin
            failures++;
            $display("FAIL %s pixel=%0d got=%0d expected=%0d", name, bad_idx,
                     heu_window[8*bad_idx +: 8], exp[8*bad_idx +: 8]);
        end
    endtask

    // Present a window for one cycle; returns after the accept edge (+1).
    task automatic start_window(input logic [WB-1:0] win);
        @(negedge clk);
        bcau_window = win;
        bcau_valid  = 1'b1;
        @(posedge clk);
        #1;
        bcau_valid = 1'b0;
    endtask

    // lat = number of clock edges from the accept edge until heu_valid seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!heu_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake_check(input string name);
        @(posedge clk);
        #1;
        check_val({name, "_valid_drop"}, int'(heu_valid), 0);
        check_val({name, "_ready_back"}, int'(heu_ready), 1);
    endtask

    initial begin
        int lat;
        int bad;
        int cdfv;
        logic [WB-1:0] ramp;
        logic [WB-1:0] ramp_eq;
        logic [WB-1:0] hold_win;

        vecs[0] = '{a: 8'd100, b: 8'd100, ea: 8'd255, eb: 8'd255};
        vecs[1] = '{a: 8'd0,   b: 8'd255, ea: 8'd127, eb: 8'd255};
        vecs[2] = '{a: 8'd7,   b: 8'd7,   ea: 8'd255, eb: 8'd255};
        vecs[3] = '{a: 8'd10,  b: 8'd20,  ea: 8'd127, eb: 8'd255};
        vecs[4] = '{a: 8'd255, b: 8'd0,   ea: 8'd255, eb: 8'd127};
        vecs[5] = '{a: 8'd50,  b: 8'd49,  ea: 8'd255, eb: 8'd127};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", int'(heu_ready), 0);
        check_val("rst_valid", int'(heu_valid), 0);
        check_win("rst_window", '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("idle_ready", int'(heu_ready), 1);
        $display("txn reset ready=%0d valid=%0d", heu_ready, heu_valid);

        // Table-driven windows, back to back
        for (int v = 0; v < 6; v++) begin
            start_window(mk_win(vecs[v].a, vecs[v].b));
            check_val("busy_ready", int'(heu_ready), 0);
            wait_valid(lat);
            check_val("latency", lat, 1057);
            check_win("vec_window", mk_win(vecs[v].ea, vecs[v].eb));
            $display("txn vec=%0d in=(%0d,%0d) lat=%0d out0=%0d out1=%0d", v,
                     vecs[v].a, vecs[v].b, lat, heu_window[7:0], heu_window[15:8]);
            handshake_check("vec");
        end

        // Ramp: 0..143 appear twice, 144..255 once
        for (int i = 0; i < WIN_PIXELS; i++) begin
            ramp[8*i +: 8] = 8'(i % 256);
            cdfv = ((i % 256) <= 143) ? 2 * ((i % 256) + 1) : 288 + ((i % 256) - 143);
            ramp_eq[8*i +: 8] = 8'((cdfv * 653) / 1024);
        end
        start_window(ramp);
        wait_valid(lat);
        check_val("ramp_latency", lat, 1057);
        check_win("ramp_window", ramp_eq);
        $display("txn ramp lat=%0d out0=%0d out255=%0d", lat, heu_window[7:0],
                 heu_window[8*255 +: 8]);
        handshake_check("ramp");

        // Backpressure: hold 50 cycles, stray bcau_valid ignored
        nnu_ready = 1'b0;
        start_window(mk_win(8'd100, 8'd100));
        wait_valid(lat);
        check_val("bp_latency", lat, 1057);
        hold_win = mk_win(8'd255, 8'd255);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            bcau_valid  = (k == 20);
            bcau_window = mk_win(8'd3, 8'd9);
            @(posedge clk);
            #1;
            if (!heu_valid || heu_ready || heu_window !== hold_win) bad++;
        end
        bcau_valid = 1'b0;
        check_val("bp_stable_errors", bad, 0);
        @(negedge clk);
        nnu_ready = 1'b1;
        handshake_check("bp");
        $display("txn backpressure hold=50 errors=%0d", bad);

        // Reset in cycle 500 (CDF), then a clean window
        start_window(mk_win(8'd0, 8'd255));
        for (int k = 1; k < 500; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_val("midrst_ready", int'(heu_ready), 0);
        check_val("midrst_valid", int'(heu_valid), 0);
        check_win("midrst_window", '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("midrst_idle_ready", int'(heu_ready), 1);
        start_window(mk_win(8'd100, 8'd100));
        wait_valid(lat);
        check_val("postrst_latency", lat, 1057);
        check_win("postrst_window", mk_win(8'd255, 8'd255));
        $display("txn reset_recovery lat=%0d out0=%0d", lat, heu_window[7:0]);
        handshake_check("postrst");

`ifdef HEU_BYPASS_EN
        bypass = 1'b1;
        start_window(ramp);
        bypass = 1'b0;
        wait_valid(lat);
        check_val("bypass_latency", lat, 1);
        check_win("bypass_window", ramp);
        $display("txn bypass lat=%0d out1=%0d", lat, heu_window[15:8]);
        handshake_check("bypass");
        start_window(mk_win(8'd0, 8'd255));
        wait_valid(lat);
        check_val("after_bypass_latency", lat, 1057);
        check_win("after_bypass_window", mk_win(8'd127, 8'd255));
        handshake_check("after_bypass");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
